// File: rtl/seq_checker.sv
// seq_checker: receive-side lock checker for the 0,2,5,7,11,14 sequence.
// Hunts for a legal value, confirms sync, flywheels while locked.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset
//   valid      in   1  qualifies datain
//   datain     in   4  received sequence value
//   locked     out  1  high while in LOCKED
//   error      out  1  one-cycle pulse per mismatch seen in LOCKED
//   lap        out  1  one-cycle pulse when 14 is matched in LOCKED
//   expected   out  4  value expected on the next valid sample
//   err_count  out  8  saturating count of error pulses
//
// Parameters:
//   LOCK_COUNT   matches in SYNC needed to lock (1..15)
//   UNLOCK_ERRS  consecutive mismatches in LOCKED that drop lock (1..15)
//
// Configuration macro:
//   SEQCHK_ERRCNT_EN  builds the err_count register; otherwise it is 0.
module seq_checker #(
    parameter int LOCK_COUNT  = 2,
    parameter int UNLOCK_ERRS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [3:0] datain,
    output logic       locked,
    output logic       error,
    output logic       lap,
    output logic [3:0] expected,
    output logic [7:0] err_count
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0] LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLCK_N = 4'(UNLOCK_ERRS);

    logic [1:0] state_q, state_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] match_q, match_d;
    logic [3:0] bad_q, bad_d;
    logic       locked_q, locked_d;
    logic       error_q, error_d;
    logic       lap_q, lap_d;

    logic [3:0] match_inc;
    logic [3:0] bad_inc;
    logic       hit;

    function automatic logic is_member(input logic [3:0] v);
        case (v)
            4'd0, 4'd2, 4'd5,
            4'd7, 4'd11, 4'd14: is_member = 1'b1;
            default:            is_member = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] nxt(input logic [3:0] v);
        case (v)
            4'd0:    nxt = 4'd2;
            4'd2:    nxt = 4'd5;
            4'd5:    nxt = 4'd7;
            4'd7:    nxt = 4'd11;
            4'd11:   nxt = 4'd14;
            default: nxt = 4'd0;
        endcase
    endfunction

    assign hit       = (datain == exp_q);
    assign match_inc = match_q + 4'd1;
    assign bad_inc   = bad_q + 4'd1;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        match_d = match_q;
        bad_d   = bad_q;
        error_d = 1'b0;
        lap_d   = 1'b0;

        if (valid) begin
            case (state_q)
                HUNT: begin
                    if (is_member(datain)) begin
                        state_d = SYNC;
                        exp_d   = nxt(datain);
                        match_d = 4'd0;
                    end
                end

                SYNC: begin
                    if (hit) begin
                        exp_d   = nxt(exp_q);
                        match_d = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_d = LOCKED;
                            bad_d   = 4'd0;
                        end
                    end else if (is_member(datain)) begin
                        exp_d   = nxt(datain);
                        match_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                        exp_d   = 4'd0;
                        match_d = 4'd0;
                    end
                end

                LOCKED: begin
                    if (hit) begin
                        exp_d = nxt(exp_q);
                        bad_d = 4'd0;
                        lap_d = (datain == 4'd14);
                    end else begin
                        // Flywheel: advance on the schedule, not on the bad value.
                        error_d = 1'b1;
                        exp_d   = nxt(exp_q);
                        bad_d   = bad_inc;
                        if (bad_inc == UNLCK_N) begin
                            state_d = HUNT;
                            exp_d   = 4'd0;
                            bad_d   = 4'd0;
                            match_d = 4'd0;
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                    exp_d   = 4'd0;
                    match_d = 4'd0;
                    bad_d   = 4'd0;
                end
            endcase
        end
    end

    assign locked_d = (state_d == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= HUNT;
            exp_q    <= 4'd0;
            match_q  <= 4'd0;
            bad_q    <= 4'd0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            lap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            lap_q    <= lap_d;
        end
    end

`ifdef SEQCHK_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (error_d && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errcnt_q <= 8'd0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_count = errcnt_q;
`else
    assign err_count = 8'd0;
`endif

    assign locked   = locked_q;
    assign error    = error_q;
    assign lap      = lap_q;
    assign expected = exp_q;

endmodule

// File: doc/seq_checker.md
# seq_checker

Receive-side checker for the 4-bit repeating count sequence 0, 2, 5, 7, 11, 14, 0, … produced upstream by the sequence counter. It samples the incoming value on qualified cycles, hunts for a legal code point, and confirms sync over consecutive correct transitions before declaring lock. While locked it flywheels through the expected sequence, flags every mismatch, and drops lock after repeated consecutive errors. It sits at the consumer end of the counter link and provides lock and error status to the rest of the design.

## Interface
- `LOCK_COUNT`, default 2: consecutive correct transitions required in SYNC before entering LOCKED; legal range 1..15.
- `UNLOCK_ERRS`, default 2: consecutive mismatches in LOCKED that force a return to HUNT; legal range 1..15.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  qualifies `datain`; the block samples only on cycles where this is 1.
- `datain`  in  4  received sequence value.
- `locked`  out  1  high while the FSM is in LOCKED.
- `error`  out  1  one-cycle pulse for a mismatch detected in LOCKED.
- `lap`  out  1  one-cycle pulse when 14 is matched in LOCKED, marking a completed lap.
- `expected`  out  4  value expected on the next valid sample; 0 when in HUNT.
- `err_count`  out  8  saturating count of `error` pulses.

## Operation
- Legal set: {0, 2, 5, 7, 11, 14}.
- `next()` mapping: 0→2, 2→5, 5→7, 7→11, 11→14, 14→0.
- Any other value is a non-member.
- FSM states are HUNT, SYNC and LOCKED; registers are `state`, `expected`, `match_cnt[3:0]` and `bad_cnt[3:0]`.
- When `valid`=0, all state holds and `error` and `lap` are 0.
- HUNT, on valid:
  - Member value: go to SYNC, set `expected`=next(datain), set `match_cnt`=0.
  - Non-member: stay in HUNT.
- SYNC, on valid:
  - `datain`==`expected`: increment `match_cnt` and advance `expected`. When the incremented `match_cnt` equals `LOCK_COUNT`, go to LOCKED and clear `bad_cnt`.
  - Mismatch, member value: restart SYNC from this value, with `expected`=next(datain) and `match_cnt`=0.
  - Mismatch, non-member: go to HUNT with `expected`=0.
- SYNC never asserts `error`.
- LOCKED, on valid:
  - Match: advance `expected` and clear `bad_cnt`. If `datain`==14, pulse `lap`.
  - Mismatch: pulse `error`, increment `err_count` (saturating at 255), increment `bad_cnt`, and set `expected`=next(expected). The flywheel ignores the bad value.
  - When the incremented `bad_cnt` equals `UNLOCK_ERRS`: go to HUNT with `expected`=0, `bad_cnt`=0 and `match_cnt`=0. `error` still pulses for this final mismatch.
- `err_count` is cleared only by reset. It is not cleared by loss of lock.

## Timing
- All outputs are registered.
- Responses appear in the cycle after the rising edge that samples `datain`; latency is 1 cycle.
- Reset values:
  - `state`=HUNT.
  - `locked`=0, `error`=0, `lap`=0.
  - `expected`=0, `err_count`=0.
  - Internal counters=0.
- Reset is asynchronous assert and is released on a clock edge. Assertion at any time, including mid-lock, immediately forces every reset value above.
- `locked` rises in the cycle after the sample that completes the `LOCK_COUNT`-th match.
- `locked` falls in the cycle after the `UNLOCK_ERRS`-th consecutive mismatch; `error` is high in that same cycle.
- Gaps in `valid` of any length are transparent: a match, mismatch or error run continues across the gap.
- `lap` and `error` are mutually exclusive.

## Configuration
- `SEQCHK_ERRCNT_EN` defined: the 8-bit saturating `err_count` register is built.
- Undefined: no counter register is built and `err_count` is tied to 8'd0. All other behaviour, including the `error` pulse, is unchanged.

## Test plan
- Lock acquisition, defaults, `valid`=1: stimulus `datain` 0, 2, 5 → `locked` rises the cycle after the 5 is sampled and `expected`=7. Continuing with 7, 11, 14 → `lap`=1 for one cycle after the 14 is sampled.
- Single error while locked: stimulus 3 where 0 is due, then 2 → `error` pulse, `err_count`=1, `expected`=2 after the error. The 2 then matches, `locked` stays 1 and `bad_cnt` clears.
- Loss of lock: two consecutive wrong values (9, 9) → two `error` pulses, `locked`=0 and `expected`=0 after the second; `err_count`=2.
- Resync and gaps: in HUNT, stimulus 7, 5 → SYNC restarts from 5. Then 7, 11 → locked. Driving `valid`=0 for 10 cycles between samples changes no output.
- Saturation and reset: inject 300 errors with `UNLOCK_ERRS`=15, relocking as needed → `err_count` holds 255. Asserting `reset` low mid-lock clears all outputs asynchronously, before the next clock edge.
- Macro off: rerun the single-error scenario without `SEQCHK_ERRCNT_EN` → `error` pulses identically and `err_count` stays 0.
